// File: rtl/fifo_wptr_full_pkg.sv
// fifo_pkg: shared pointer definitions and Gray-code helpers for the FIFO
// pointer stages.
//   ADDR_SIZE : default address width (DEPTH = 2**ADDR_SIZE)
//   PTR_W     : pointer width, one wrap bit above the address
//   ptr_t     : pointer type at the default width
//   bin2gray / gray2bin operate on a zero-extended 32-bit word, so that
//   instances with an overridden ADDR_SIZE can reuse them by truncating
//   the result.
package fifo_pkg;

  localparam int ADDR_SIZE = 4;
  localparam int PTR_W     = ADDR_SIZE + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [31:0]      word_t;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Running XOR from the MSB down. Zero upper bits leave the lower
  // result unchanged.
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// fifo_wptr_full_if: write-side signals of the FIFO pointer stage.
//   master : the producer / surrounding FIFO (drives winc, rptr_gray_in)
//   slave  : fifo_wptr_full (drives address, Gray pointer and flags)
interface fifo_wptr_full_if #(
  parameter int ADDR_SIZE = fifo_pkg::ADDR_SIZE
);
  logic                 winc;          // push request
  logic [ADDR_SIZE:0]   rptr_gray_in;  // Gray read pointer, read clock domain
  logic [ADDR_SIZE-1:0] waddr;         // RAM write address
  logic [ADDR_SIZE:0]   wptr_gray;     // registered Gray write pointer
  logic                 wfull;         // FIFO full
  logic                 walmost_full;  // level >= DEPTH-AF_MARGIN
  logic [ADDR_SIZE:0]   wlevel;        // fill level seen by the writer
  logic                 wovf;          // push dropped because full

  modport master (
    output winc, rptr_gray_in,
    input  waddr, wptr_gray, wfull, walmost_full, wlevel, wovf
  );

  modport slave (
    input  winc, rptr_gray_in,
    output waddr, wptr_gray, wfull, walmost_full, wlevel, wovf
  );
endinterface

// File: rtl/fifo_wptr_full_sync.sv
// sync_2ff: two-flop synchroniser for a multi-bit Gray-coded bus.
// Safe only because the source changes at most one bit per source-clock edge.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : asynchronous input
//   q     : synchronised output (second stage)
module sync_2ff #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q1;

  // Two-stage synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= {WIDTH{1'b0}};
      q  <= {WIDTH{1'b0}};
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end
endmodule

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-side pointer and flag stage of the FIFO.
// Holds the binary write pointer, drives the RAM write address, publishes a
// registered Gray write pointer, synchronises the Gray read pointer and
// derives full, almost-full, fill level and an overflow pulse.
//   clk   : write-domain clock
//   rst_n : asynchronous active-low reset
//   bus   : fifo_wptr_full_if.slave (winc, rptr_gray_in in; waddr,
//           wptr_gray, wfull, walmost_full, wlevel, wovf out)
module fifo_wptr_full #(
  parameter int ADDR_SIZE = fifo_pkg::ADDR_SIZE,
  parameter int AF_MARGIN = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_wptr_full_if.slave bus
);
  import fifo_pkg::*;

  localparam int             PW       = ADDR_SIZE + 1;
  localparam int             DEPTH    = 1 << ADDR_SIZE;
  localparam logic [PW-1:0]  AF_LEVEL = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] wbin;
  logic [PW-1:0] rq2;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] level_next;
  logic [PW-1:0] rq2_full;
  logic          push;
  logic          full_next;
  logic          af_next;

  sync_2ff #(.WIDTH(PW)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.rptr_gray_in),
    .q     (rq2)
  );

  // Next pointer values and flags computed from the post-push pointer, so
  // full asserts on the same edge that accepts the filling push.
  always_comb begin
    push       = bus.winc & ~bus.wfull;
    wbin_next  = wbin + {{(PW-1){1'b0}}, push};
    wgray_next = PW'(bin2gray(32'(wbin_next)));
    rbin_sync  = PW'(gray2bin(32'(rq2)));
    level_next = wbin_next - rbin_sync;
    // Full in Gray: read pointer one lap behind -> top two bits inverted.
    rq2_full   = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
    full_next  = (wgray_next == rq2_full);
    af_next    = (level_next >= AF_LEVEL);
  end

  // Pointer and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin             <= {PW{1'b0}};
      bus.wptr_gray    <= {PW{1'b0}};
      bus.wfull        <= 1'b0;
      bus.walmost_full <= 1'b0;
      bus.wlevel       <= {PW{1'b0}};
      bus.wovf         <= 1'b0;
    end else begin
      wbin             <= wbin_next;
      bus.wptr_gray    <= wgray_next;
      bus.wfull        <= full_next;
      bus.walmost_full <= af_next;
      bus.wlevel       <= level_next;
      bus.wovf         <= bus.winc & bus.wfull;
    end
  end

  // Pre-increment address: the RAM writes here while the push is accepted.
  assign bus.waddr = wbin[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full (ADDR_SIZE=4, AF_MARGIN=2).
// The driver pushes the expected post-edge outputs into a queue; a monitor
// on the falling edge pops and compares, and also checks that wptr_gray
// moves by at most one bit per clock edge.
module tb_fifo_wptr_full;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wptr_full_if #(.ADDR_SIZE(4)) bus ();

  fifo_wptr_full #(.ADDR_SIZE(4), .AF_MARGIN(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] waddr;
    logic [4:0] gray;
    logic       full;
    logic       af;
    logic [4:0] level;
    logic       ovf;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [4:0] prev_gray = 5'd0;
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".waddr"},        32'(bus.waddr),        32'(e.waddr));
    chk({tag, ".wptr_gray"},    32'(bus.wptr_gray),    32'(e.gray));
    chk({tag, ".wfull"},        32'(bus.wfull),        32'(e.full));
    chk({tag, ".walmost_full"}, 32'(bus.walmost_full), 32'(e.af));
    chk({tag, ".wlevel"},       32'(bus.wlevel),       32'(e.level));
    chk({tag, ".wovf"},         32'(bus.wovf),         32'(e.ovf));
  endtask

  function automatic exp_t mk(input int addr, input int gray, input bit full,
                              input bit af, input int level, input bit ovf);
    exp_t e;
    e.waddr = 4'(addr);
    e.gray  = 5'(gray);
    e.full  = full;
    e.af    = af;
    e.level = 5'(level);
    e.ovf   = ovf;
    return e;
  endfunction

  function automatic int g(input int k);
    int m;
    m = k % 32;
    return m ^ (m >> 1);
  endfunction

  // One clock of stimulus; the expected post-edge state goes to the scoreboard.
  task automatic step(input logic w, input logic [4:0] rp, input exp_t e);
    @(negedge clk);
    bus.winc         = w;
    bus.rptr_gray_in = rp;
    @(posedge clk);
    exp_q.push_back(e);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_out(tag, mk(0, 0, 1'b0, 1'b0, 0, 1'b0));
    @(negedge clk);
    bus.winc         = 1'b0;
    bus.rptr_gray_in = 5'd0;
    #2 rst_n = 1'b1;
  endtask

  // Scoreboard monitor plus one-bit-per-edge Gray check.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_out("sb", mon_e);
    end
    if (!rst_n) begin
      prev_gray = 5'd0;
    end else begin
      chk("gray_one_bit", 32'($countones(bus.wptr_gray ^ prev_gray) <= 1), 32'd1);
      prev_gray = bus.wptr_gray;
    end
  end

  initial begin
    int r;
    bus.winc         = 1'b0;
    bus.rptr_gray_in = 5'd0;

    // Power-on reset state.
    repeat (2) @(negedge clk);
    check_out("por", mk(0, 0, 1'b0, 1'b0, 0, 1'b0));
    #2 rst_n = 1'b1;
    step(1'b0, 5'd0, mk(0, 0, 1'b0, 1'b0, 0, 1'b0));

    // Short burst, then reset asserted mid-burst between edges.
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 5'd0, mk(k, g(k), 1'b0, 1'b0, k, 1'b0));
    end
    do_reset("midreset");

    // Fill: 16 pushes, reader parked at 0.
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 5'd0, mk(k % 16, g(k), k == 16, k >= 14, k, 1'b0));
    end

    // Overflow: one rejected push, pulse lasts one cycle.
    step(1'b1, 5'd0, mk(0, 5'b11000, 1'b1, 1'b1, 16, 1'b1));
    step(1'b0, 5'd0, mk(0, 5'b11000, 1'b1, 1'b1, 16, 1'b0));

    // Release: reader advances by one; visible after the third edge.
    step(1'b0, 5'b00001, mk(0, 5'b11000, 1'b1, 1'b1, 16, 1'b0));
    step(1'b0, 5'b00001, mk(0, 5'b11000, 1'b1, 1'b1, 16, 1'b0));
    step(1'b0, 5'b00001, mk(0, 5'b11000, 1'b0, 1'b1, 15, 1'b0));

    // Wrap: fresh start, continuous push, reader trails two pushes behind the
    // input so the synchronised view trails by four.
    do_reset("prewrap");
    for (int i = 1; i <= 40; i++) begin
      r = (i >= 2) ? i - 2 : 0;
      step(1'b1, 5'(g(r)), mk(i % 16, g(i), 1'b0, 1'b0, (i < 4) ? i : 4, 1'b0));
    end
    step(1'b0, 5'(g(38)), mk(40 % 16, g(40), 1'b0, 1'b0, 3, 1'b0));

    // Drain the scoreboard within a bounded number of cycles.
    repeat (3) @(negedge clk);
    #1 chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
